milano_ctrl_fsm: RTL
====================

Name: milano_ctrl_fsm

Overview:
Multi-cycle instruction sequencer for the milano core. It fetches one instruction at a time over a req/valid handshake and classifies it by opcode (opcode_e). It then drives the ALU operation select (alu_opt_e) and steps the instruction through EXECUTE, MEM and WB as needed. It sits between the fetch/LSU interfaces and the datapath (ALU, register file, PC).

Parameters:
- BOOT_WAIT, 1, number of IDLE cycles after reset release before the first fetch (≥1).

Ports:
- clk_i  in  1  core clock.
- rst_i  in  1  synchronous reset, active-high.
- instr_req_o  out  1  fetch request.
- instr_valid_i  in  1  instr_rdata_i valid; completes the fetch.
- instr_rdata_i  in  32  fetched instruction.
- instr_o  out  32  latched instruction, to datapath decode.
- alu_en_o  out  1  ALU result capture enable.
- alu_op_o  out  10  alu_opt_e select.
- data_req_o  out  1  LSU request.
- data_we_o  out  1  1 = store, 0 = load.
- data_valid_i  in  1  LSU done (load data valid / store accepted).
- branch_taken_i  in  1  branch comparator result, sampled in EXECUTE.
- pc_set_o  out  1  load PC with target; otherwise PC += 4 at WB/commit.
- pc_inc_o  out  1  sequential PC advance.
- rf_we_o  out  1  register-file write enable.
- halted_o  out  1  core halted (sticky until reset).
- illegal_insn_o  out  1  halt cause is an illegal instruction (sticky).

Behaviour:
- States: IDLE, FETCH, DECODE, EXECUTE, MEM, WB, HALT. All outputs are Moore decodes of the state and the latched instruction.
- Reset (rst_i=1 at a clock edge):
  - state←IDLE, instr_o←0, idle counter←0.
  - All outputs are 0 while in IDLE.
  - Reset mid-operation aborts any outstanding fetch or LSU request with no commit; a late instr_valid_i or data_valid_i is ignored.
- IDLE: stays for BOOT_WAIT cycles, then →FETCH.
- FETCH:
  - instr_req_o=1 until instr_valid_i=1.
  - On that cycle instr_o←instr_rdata_i, →DECODE.
  - Minimum 1 cycle; unbounded wait.
- DECODE (1 cycle), transitions by instruction:
  - instr[1:0]≠2'b11 or unknown opcode → HALT, illegal_insn_o←1.
  - OPCODE_SYSTEM → HALT.
  - OPCODE_MISC_MEM → pc_inc_o=1 this cycle, →FETCH.
  - All other opcodes → EXECUTE.
- EXECUTE (1 cycle):
  - alu_en_o=1.
  - alu_op_o=ALU_SUB iff opcode=OPCODE_OP, funct3=000 and funct7=0x20; otherwise ALU_ADD. ALU_ADD covers address, AUIPC, LUI and link arithmetic.
  - BRANCH: pc_set_o=branch_taken_i, pc_inc_o=!branch_taken_i, →FETCH.
  - LOAD/STORE: →MEM.
  - Others: →WB.
- MEM:
  - data_req_o=1; data_we_o=1 for STORE, 0 for LOAD. Held until data_valid_i.
  - STORE done: pc_inc_o=1, →FETCH.
  - LOAD done: →WB.
- WB (1 cycle):
  - rf_we_o=1 unless rd=x0 (instr[11:7]=0).
  - JAL/JALR: pc_set_o=1; others: pc_inc_o=1.
  - →FETCH.
- HALT:
  - halted_o=1; no requests issued.
  - Exits only via reset; illegal_insn_o holds its value.
- Latencies with zero-wait handshakes, FETCH entry to next FETCH:
  - ALU/LUI/AUIPC/JAL/JALR: 4 cycles.
  - Branch: 3 cycles.
  - Load: 5 cycles.
  - Store: 4 cycles.
  - FENCE: 2 cycles.
- Exactly one of pc_set_o and pc_inc_o pulses per committed instruction; neither is ever high in the same cycle.
- A valid input asserted outside its wait state (FETCH/MEM) is ignored.

Optional Feature:
- MILANO_CTRL_PERF_EN defined: adds outputs retired_o (32 b) and stall_o (32 b).
  - retired_o increments on each pc_set_o/pc_inc_o pulse.
  - stall_o increments each FETCH or MEM cycle in which the matching valid is low.
  - Both clear on reset and wrap modulo 2^32.
- Undefined: neither port nor counter exists; behaviour is otherwise identical.

Test Plan:
- ADD: reset 2 cycles, BOOT_WAIT=1, feed 0x002081B3 with zero-wait valid.
  - Required: instr_req_o high 1 cycle; EXECUTE alu_op_o=ALU_ADD; WB rf_we_o=1 and pc_inc_o=1; next fetch 4 cycles after the first.
- SUB: feed 0x402081B3 → alu_op_o=ALU_SUB in EXECUTE.
- Load with wait: feed 0x0040A283, hold data_valid_i low 3 cycles.
  - Required: data_req_o=1 and data_we_o=0 for 4 cycles; then WB rf_we_o=1; stall_o=3 when perf is enabled.
- Store then branch:
  - Store 0x0050A223 → data_we_o=1, no rf_we_o, pc_inc_o on data_valid_i.
  - Branch 0x00208463 with branch_taken_i=1 → pc_set_o=1 in EXECUTE, no WB.
  - Branch 0x00208463 with branch_taken_i=0 → pc_inc_o=1 instead.
- Halt cases:
  - 0x00000000 → HALT, halted_o=1, illegal_insn_o=1, instr_req_o stays 0 for 20 cycles.
  - 0x00000073 → halted_o=1, illegal_insn_o=0.
- Reset mid-MEM: assert rst_i during a load with data_valid_i low.
  - Required: next cycle state IDLE, all outputs 0, no rf_we_o; a subsequent data_valid_i pulse is ignored.

Source files
------------

// File: rtl/milano_ctrl_fsm.sv
// milano_ctrl_fsm: multi-cycle instruction sequencer for the milano core
//
// Fetches one instruction over a req/valid handshake, classifies it by opcode,
// then steps it through EXECUTE, MEM and WB as needed.
// Optional macro MILANO_CTRL_PERF_EN adds retired/stall performance counters.
//
// Ports:
//   clk_i            core clock
//   rst_i            synchronous reset, active-high
//   instr_req_o      fetch request
//   instr_valid_i    instr_rdata_i valid, completes the fetch
//   instr_rdata_i    fetched instruction
//   instr_o          latched instruction to datapath decode
//   alu_en_o         ALU result capture enable
//   alu_op_o         ALU operation select (alu_opt_e)
//   data_req_o       LSU request
//   data_we_o        1 = store, 0 = load
//   data_valid_i     LSU done
//   branch_taken_i   branch comparator result, sampled in EXECUTE
//   pc_set_o         load PC with target
//   pc_inc_o         sequential PC advance
//   rf_we_o          register-file write enable
//   halted_o         core halted, sticky until reset
//   illegal_insn_o   halt cause is an illegal instruction, sticky
//   retired_o        retired instruction count (MILANO_CTRL_PERF_EN only)
//   stall_o          handshake stall cycle count (MILANO_CTRL_PERF_EN only)
module milano_ctrl_fsm #(
    parameter int unsigned BOOT_WAIT = 1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    output logic        instr_req_o,
    input  logic        instr_valid_i,
    input  logic [31:0] instr_rdata_i,
    output logic [31:0] instr_o,
    output logic        alu_en_o,
    output logic [9:0]  alu_op_o,
    output logic        data_req_o,
    output logic        data_we_o,
    input  logic        data_valid_i,
    input  logic        branch_taken_i,
    output logic        pc_set_o,
    output logic        pc_inc_o,
    output logic        rf_we_o,
    output logic        halted_o,
    output logic        illegal_insn_o
`ifdef MILANO_CTRL_PERF_EN
    ,
    output logic [31:0] retired_o,
    output logic [31:0] stall_o
`endif
);

    typedef enum logic [6:0] {
        OPCODE_LOAD     = 7'h03,
        OPCODE_MISC_MEM = 7'h0f,
        OPCODE_OP_IMM   = 7'h13,
        OPCODE_AUIPC    = 7'h17,
        OPCODE_STORE    = 7'h23,
        OPCODE_OP       = 7'h33,
        OPCODE_LUI      = 7'h37,
        OPCODE_BRANCH   = 7'h63,
        OPCODE_JALR     = 7'h67,
        OPCODE_JAL      = 7'h6f,
        OPCODE_SYSTEM   = 7'h73
    } opcode_e;

    // ALU_ADD is encoded as zero so the idle value of alu_op_o is all-zero.
    typedef enum logic [9:0] {
        ALU_ADD  = 10'd0,
        ALU_SUB  = 10'd1,
        ALU_XOR  = 10'd2,
        ALU_OR   = 10'd3,
        ALU_AND  = 10'd4,
        ALU_SLL  = 10'd5,
        ALU_SRL  = 10'd6,
        ALU_SRA  = 10'd7,
        ALU_SLT  = 10'd8,
        ALU_SLTU = 10'd9
    } alu_opt_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXECUTE,
        S_MEM,
        S_WB,
        S_HALT
    } state_e;

    localparam int unsigned CW = (BOOT_WAIT > 1) ? $clog2(BOOT_WAIT) : 1;

    state_e         state_q, state_d;
    logic [31:0]    instr_q, instr_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           illegal_q, illegal_d;

    logic [6:0]     opc;
    logic           is_legal, is_system, is_fence, is_branch;
    logic           is_load, is_store, is_jump, is_sub;

    always_comb begin
        opc       = instr_q[6:0];
        is_legal  = (instr_q[1:0] == 2'b11) && (opc inside {OPCODE_LOAD, OPCODE_MISC_MEM,
                    OPCODE_OP_IMM, OPCODE_AUIPC, OPCODE_STORE, OPCODE_OP, OPCODE_LUI,
                    OPCODE_BRANCH, OPCODE_JALR, OPCODE_JAL, OPCODE_SYSTEM});
        is_system = opc == OPCODE_SYSTEM;
        is_fence  = opc == OPCODE_MISC_MEM;
        is_branch = opc == OPCODE_BRANCH;
        is_load   = opc == OPCODE_LOAD;
        is_store  = opc == OPCODE_STORE;
        is_jump   = (opc == OPCODE_JAL) || (opc == OPCODE_JALR);
        is_sub    = (opc == OPCODE_OP) && (instr_q[14:12] == 3'b000) && (instr_q[31:25] == 7'h20);
    end

    always_comb begin
        state_d     = state_q;
        instr_d     = instr_q;
        cnt_d       = cnt_q;
        illegal_d   = illegal_q;
        instr_req_o = 1'b0;
        alu_en_o    = 1'b0;
        alu_op_o    = ALU_ADD;
        data_req_o  = 1'b0;
        data_we_o   = 1'b0;
        pc_set_o    = 1'b0;
        pc_inc_o    = 1'b0;
        rf_we_o     = 1'b0;
        halted_o    = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (cnt_q == CW'(BOOT_WAIT - 1)) state_d = S_FETCH;
                else cnt_d = cnt_q + 1'b1;
            end
            S_FETCH: begin
                instr_req_o = 1'b1;
                if (instr_valid_i) begin
                    instr_d = instr_rdata_i;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                if (!is_legal) begin
                    illegal_d = 1'b1;
                    state_d   = S_HALT;
                end else if (is_system) begin
                    state_d = S_HALT;
                end else if (is_fence) begin
                    pc_inc_o = 1'b1;
                    state_d  = S_FETCH;
                end else begin
                    state_d = S_EXECUTE;
                end
            end
            S_EXECUTE: begin
                alu_en_o = 1'b1;
                alu_op_o = is_sub ? ALU_SUB : ALU_ADD;
                if (is_branch) begin
                    pc_set_o = branch_taken_i;
                    pc_inc_o = !branch_taken_i;
                    state_d  = S_FETCH;
                end else begin
                    state_d = (is_load || is_store) ? S_MEM : S_WB;
                end
            end
            S_MEM: begin
                data_req_o = 1'b1;
                data_we_o  = is_store;
                if (data_valid_i) begin
                    pc_inc_o = is_store;
                    state_d  = is_store ? S_FETCH : S_WB;
                end
            end
            S_WB: begin
                rf_we_o  = instr_q[11:7] != 5'd0;
                pc_set_o = is_jump;
                pc_inc_o = !is_jump;
                state_d  = S_FETCH;
            end
            S_HALT: halted_o = 1'b1;
            default: state_d = S_IDLE;
        endcase
    end

    assign instr_o        = instr_q;
    assign illegal_insn_o = illegal_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= S_IDLE;
            instr_q   <= '0;
            cnt_q     <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            instr_q   <= instr_d;
            cnt_q     <= cnt_d;
            illegal_q <= illegal_d;
        end
    end

`ifdef MILANO_CTRL_PERF_EN
    logic [31:0] retired_q, retired_d, stall_q, stall_d;

    always_comb begin
        retired_d = retired_q + 32'(pc_set_o | pc_inc_o);
        stall_d   = stall_q + 32'((state_q == S_FETCH && !instr_valid_i) ||
                                  (state_q == S_MEM && !data_valid_i));
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            retired_q <= '0;
            stall_q   <= '0;
        end else begin
            retired_q <= retired_d;
            stall_q   <= stall_d;
        end
    end

    assign retired_o = retired_q;
    assign stall_o   = stall_q;
`endif

endmodule
